// File: rtl/unified_mem_arbiter.sv
// Shares one single-port unified memory between the CPU fetch port and the load/store port.
// The data port has priority. A starvation counter forces a fetch grant after STARVE_MAX data grants.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_d
);
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                gnt_d_q, gnt_d_d;
    logic                we_q, we_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                busy_q, busy_d;
    logic                grant_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            starve_q    <= '0;
            gnt_d_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            gnt_d_q     <= gnt_d_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic. Every output is computed one cycle ahead so that it leaves a register.
    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        gnt_d_d     = gnt_d_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        grant_data  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!if_req) begin
                    starve_d = '0;
                end
                if (d_req || if_req) begin
                    // A pending fetch overrides data once the starvation counter is saturated.
                    grant_data = d_req && !(if_req && (starve_q == STARVE_W'(STARVE_MAX)));
                    if (grant_data) begin
                        gnt_d_d     = 1'b1;
                        we_d        = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_we_d    = d_we;
                        if (if_req && (starve_q < STARVE_W'(STARVE_MAX))) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        gnt_d_d     = 1'b0;
                        we_d        = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                    mem_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_d   = LAT_W'(1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(MEM_LAT)) begin
                    if (!we_q) begin
                        if (gnt_d_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    if_ack_d = !gnt_d_q;
                    d_ack_d  = gnt_d_q;
                    state_d  = ST_ACK;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign gnt_d     = gnt_d_q;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the CPU fetch port and the CPU load/store port.
- Sits between the CPU core (PC/imem fetch path and dmem access path) and the physical memory.
- Runs a request/ack handshake per port and serialises accesses through a small FSM.
- Data port has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 16, address width of both ports and the memory.
- DATA_W, 16, data word width.
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive data grants allowed while if_req is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high with stable if_addr until if_ack.
- if_addr  in  ADDR_W  fetch address (the PC).
- if_rdata  out  DATA_W  fetched instruction; valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high with stable d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en.
- busy  out  1  high whenever the FSM is not in IDLE.
- gnt_d  out  1  owner of the current transaction: 1 = data, 0 = fetch; held until the ack cycle.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including if_rdata, d_rdata, mem_* and the starvation counter.
  - Reset mid-transaction abandons the transaction; no ack is issued for it afterwards.
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - No request pending: stay in IDLE.
  - Otherwise arbitrate, latch the winner's address, write data, we and gnt_d, and go to ISSUE.
- Arbitration:
  - If d_req and if_req are both high, data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - Only one request high: that requester wins.
- starve_cnt:
  - Increments on each data grant while if_req is high.
  - Clears on a fetch grant or whenever if_req is low in IDLE.
  - Saturates at STARVE_MAX.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_we/mem_addr/mem_wdata come from the latched values.
  - Then go to WAIT with lat_cnt=1.
- WAIT:
  - While lat_cnt<MEM_LAT: increment lat_cnt.
  - When lat_cnt==MEM_LAT: capture mem_rdata into the owner's rdata register (loads/fetches only), then go to ACK.
- ACK:
  - The owner's ack=1 for exactly one cycle; the other ack stays 0. Then go to IDLE.
- Latency: a request sampled in IDLE at cycle T produces mem_en at T+1 and ack at T+2+MEM_LAT (T+3 for the default MEM_LAT).
- Throughput: one transaction per MEM_LAT+3 cycles.
- Handshake:
  - The requester may drop or change req in the cycle after ack. That value is treated as a new request.
  - A req dropped mid-transaction does not cancel it; the transaction still completes and acks.
- rdata hold:
  - if_rdata/d_rdata hold their last captured value until the next capture for that port.
  - Stores never update d_rdata.
- Ack exclusivity: if_ack and d_ack are never high in the same cycle.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010, mem returns 0xA5C3 at MEM_LAT=1 → mem_en at cycle 1 with mem_addr=0x0010, mem_we=0; if_ack=1 and if_rdata=0xA5C3 at cycle 3; busy=1 over cycles 1–3.
- Store then load:
  - Store d_we=1, d_addr=0x0100, d_wdata=0x1234 → mem_we=1 and mem_wdata=0x1234 at ISSUE; d_ack after 3 cycles; d_rdata unchanged.
  - Following load of 0x0100 (model returns 0x1234) → d_rdata=0x1234 at d_ack.
- Simultaneous requests, STARVE_MAX=4, both reqs held continuously → grant order D,D,D,D,F,D,D,D,D,F; if_ack and d_ack never coincide.
- Req drop mid-transaction: d_req deasserted during WAIT → transaction completes, d_ack still pulses once, FSM returns to IDLE, no extra mem_en.
- Reset mid-op: rst=1 during WAIT → next cycle all outputs 0, state IDLE, no ack ever issued for the abandoned access; a new if_req afterwards completes normally.
- MEM_LAT=3: fetch of 0x0020 → mem_en at cycle 1, capture at cycle 4, if_ack at cycle 5.
